// File: rtl/sparse_compress.sv
// Streaming bit-position encoder: turns dense bytes into one (bitIndx, byteIndx) code per set bit,
// lowest bit first, with zero bytes consuming an index but emitting nothing.
module sparse_compress #(
  parameter int IDX_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             work,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [2:0]       bitIndx,
  output logic [IDX_W-1:0] byteIndx,
  output logic             code_last,
  output logic             code_valid,
  input  logic             code_ready,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_EMIT, S_DONE} state_t;

  state_t           r_state;
  logic [7:0]       r_hold;
  logic [IDX_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_byte_idx;

  logic w_last;
  logic w_in_xfer;
  logic w_code_xfer;
  logic w_in_nonzero;

  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    lowest_set = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_set = 3'(i);
    end
  endfunction

  function automatic logic [7:0] clear_lowest(input logic [7:0] v);
    clear_lowest = v & (v - 8'd1);
  endfunction

  assign w_last       = (r_hold != 8'd0) && (clear_lowest(r_hold) == 8'd0);
  assign code_valid   = (r_state == S_EMIT);
  assign done         = (r_state == S_DONE);
  assign code_last    = code_valid && w_last;
  assign bitIndx      = lowest_set(r_hold);
  assign byteIndx     = r_byte_idx;
  assign w_code_xfer  = code_valid && code_ready;
  assign w_in_nonzero = (in_byte != 8'd0);

  // The final code of a byte opens the input in the same cycle, giving zero-bubble streaming.
  assign in_ready  = work && ((r_state == S_ACCEPT) ||
                              ((r_state == S_EMIT) && w_last && code_ready));
  assign w_in_xfer = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_hold     <= 8'd0;
      r_cnt      <= '0;
      r_byte_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (work) begin
            r_cnt   <= '0;
            r_state <= S_ACCEPT;
          end
        end
        S_ACCEPT: begin
          if (w_in_xfer) begin
            r_cnt <= r_cnt + IDX_W'(1);
            if (w_in_nonzero) begin
              r_hold     <= in_byte;
              r_byte_idx <= r_cnt;
              r_state    <= S_EMIT;
            end
          end else if (!work) begin
            r_state <= S_DONE;
          end
        end
        S_EMIT: begin
          if (w_code_xfer) begin
            if (!w_last) begin
              r_hold <= clear_lowest(r_hold);
            end else if (w_in_xfer) begin
              r_cnt <= r_cnt + IDX_W'(1);
              if (w_in_nonzero) begin
                r_hold     <= in_byte;
                r_byte_idx <= r_cnt;
              end else begin
                r_hold  <= 8'd0;
                r_state <= S_ACCEPT;
              end
            end else begin
              r_hold  <= 8'd0;
              r_state <= work ? S_ACCEPT : S_DONE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sparse_compress.sv
// Directed bench for sparse_compress: two instances (32-bit and 2-bit index) share all stimulus.
module tb_sparse_compress;

  logic        clk;
  logic        rst_n;
  logic        work;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        code_ready;

  logic        in_ready, code_last, code_valid, done;
  logic [2:0]  bitIndx;
  logic [31:0] byteIndx;

  logic        in_ready2, code_last2, code_valid2, done2;
  logic [2:0]  bitIndx2;
  logic [1:0]  byteIndx2;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  logic [35:0] q[$];
  logic [35:0] q2[$];
  int          qc[$];

  sparse_compress #(.IDX_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .work(work), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready), .bitIndx(bitIndx), .byteIndx(byteIndx), .code_last(code_last),
    .code_valid(code_valid), .code_ready(code_ready), .done(done)
  );

  sparse_compress #(.IDX_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .work(work), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready2), .bitIndx(bitIndx2), .byteIndx(byteIndx2), .code_last(code_last2),
    .code_valid(code_valid2), .code_ready(code_ready), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs only change just after a rising edge, so the falling edge sees what the next edge transfers.
  always @(negedge clk) begin
    if (code_valid && code_ready) begin
      q.push_back({bitIndx, byteIndx, code_last});
      qc.push_back(cyc);
    end
    if (code_valid2 && code_ready) q2.push_back({bitIndx2, 30'd0, byteIndx2, code_last2});
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int t = 0;
    in_byte  = b;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 50);
    if (!in_ready) check_eq("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_codes(input string tag, input int n);
    int t = 0;
    while (q.size() < n && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check_eq(tag, 64'(q.size()), 64'(n));
  endtask

  task automatic check_code(input string tag, input int i, input logic [2:0] b,
                            input logic [31:0] idx, input logic last);
    if (i < q.size()) check_eq(tag, 64'(q[i]), 64'({b, idx, last}));
    else check_eq({tag, "_missing"}, 64'(q.size()), 64'(i + 1));
  endtask

  task automatic new_job;
    int t = 0;
    work = 1'b0;
    while (!done && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_eq("done_set", 64'(done), 64'd1);
    check_eq("done_in_ready", 64'(in_ready), 64'd0);
    work = 1'b1;
    @(posedge clk);
    #1;
    check_eq("done_clear", 64'(done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; work = 1'b0; in_byte = 8'h00; in_valid = 1'b0; code_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    check_eq("rst_code_valid", 64'(code_valid), 64'd0);
    check_eq("rst_code_last", 64'(code_last), 64'd0);
    check_eq("rst_bitIndx", 64'(bitIndx), 64'd0);
    check_eq("rst_byteIndx", 64'(byteIndx), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    work = 1'b1;
    code_ready = 1'b1;

    // zero byte consumes index 0, then 0x81 at index 1
    send(8'h00);
    send(8'h81);
    wait_codes("t1_count", 2);
    check_code("t1_code0", 0, 3'd0, 32'd1, 1'b0);
    check_code("t1_code1", 1, 3'd7, 32'd1, 1'b1);

    // 0xFF with a 3-cycle stall on the second code
    new_job();
    q.delete();
    send(8'hFF);
    @(negedge clk);
    check_eq("t2_first_bit", 64'(bitIndx), 64'd0);
    @(posedge clk);
    #1;
    code_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check_eq("t2_stall_valid", 64'(code_valid), 64'd1);
      check_eq("t2_stall_bit", 64'(bitIndx), 64'd1);
      check_eq("t2_stall_idx", 64'(byteIndx), 64'd0);
      check_eq("t2_stall_last", 64'(code_last), 64'd0);
      check_eq("t2_stall_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    code_ready = 1'b1;
    wait_codes("t2_count", 8);
    for (int i = 0; i < 8; i++) check_code("t2_code", i, 3'(i), 32'd0, (i == 7));

    // back-to-back single-bit bytes, one code per cycle
    new_job();
    q.delete();
    qc.delete();
    send(8'h01);
    send(8'h02);
    send(8'h04);
    wait_codes("t3_count", 3);
    check_code("t3_code0", 0, 3'd0, 32'd0, 1'b1);
    check_code("t3_code1", 1, 3'd1, 32'd1, 1'b1);
    check_code("t3_code2", 2, 3'd2, 32'd2, 1'b1);
    if (qc.size() == 3) begin
      check_eq("t3_gap01", 64'(qc[1] - qc[0]), 64'd1);
      check_eq("t3_gap12", 64'(qc[2] - qc[1]), 64'd1);
    end

    // work drops during the first code of 0x0A
    new_job();
    q.delete();
    send(8'h0A);
    work = 1'b0;
    wait_codes("t4_count", 2);
    check_code("t4_code0", 0, 3'd1, 32'd0, 1'b0);
    check_code("t4_code1", 1, 3'd3, 32'd0, 1'b1);
    check_eq("t4_done", 64'(done), 64'd1);
    check_eq("t4_in_ready", 64'(in_ready), 64'd0);
    work = 1'b1;
    @(posedge clk);
    #1;
    check_eq("t4_done_clear", 64'(done), 64'd0);
    q.delete();
    send(8'h01);
    wait_codes("t4_restart_count", 1);
    check_code("t4_restart", 0, 3'd0, 32'd0, 1'b1);

    // asynchronous reset while emitting 0xF0 (at index 1)
    new_job();
    q.delete();
    send(8'h00);
    code_ready = 1'b0;
    send(8'hF0);
    @(negedge clk);
    check_eq("t5_pre_valid", 64'(code_valid), 64'd1);
    check_eq("t5_pre_bit", 64'(bitIndx), 64'd4);
    check_eq("t5_pre_idx", 64'(byteIndx), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_valid", 64'(code_valid), 64'd0);
    check_eq("t5_rst_done", 64'(done), 64'd0);
    check_eq("t5_rst_idx", 64'(byteIndx), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    code_ready = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("t5_no_codes", 64'(q.size()), 64'd0);
    check_eq("t5_done_after", 64'(done), 64'd0);

    // index wrap on the 2-bit instance
    new_job();
    q.delete();
    q2.delete();
    for (int i = 0; i < 5; i++) send(8'h01);
    wait_codes("t6_count", 5);
    check_eq("t6_count2", 64'(q2.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < q2.size()) check_eq("t6_wrap", 64'(q2[i]), 64'({3'd0, 30'd0, 2'(i % 4), 1'b1}));
      check_code("t6_wide", i, 3'd0, 32'(i), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
